// File: rtl/dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// dma_priority_arbiter
//
// Channel arbiter and bus-hold sequencer for the four-channel DMA controller.
// Qualifies DREQ with the mask register, picks a winner from the live
// priority order (fixed or rotating), runs the HRQ/HLDA hold handshake with
// the CPU and drives a one-hot DACK for the duration of one service.
//
// Optional feature macro: DMA_SW_REQUEST_EN
//   Adds a 4-bit software request register (swReqWe/swReqData) whose bits
//   bypass maskReg and clear when the service of that channel ends.
//
// Ports:
//   CLK               in   system clock, rising edge
//   RESET             in   asynchronous active-high reset
//   DREQ[3:0]         in   level-sensitive channel requests
//   maskReg[3:0]      in   1 = channel ignored
//   priorityType      in   0 = fixed (ch0 highest), 1 = rotating
//   controllerDisable in   1 = no new HRQ from IDLE
//   HLDA              in   hold acknowledge from the CPU
//   serviceDone       in   one-cycle pulse, current service finished
//   swReqWe           in   software request write strobe (macro only)
//   swReqData[2:0]    in   [2] set/clear, [1:0] channel (macro only)
//   HRQ               out  hold request to the CPU
//   DACK[3:0]         out  one-hot grant
//   grantValid        out  1 while DACK is non-zero
//   grantChannel[1:0] out  encoded grant, holds last value when idle
//   priorityOrder[7:0]out  channel IDs, [1:0] highest .. [7:6] lowest
//   state_dbg[1:0]    out  current sequencer state (debug observation)
//
// Handshake: HRQ is a request held high until the sequencer releases the
// bus; HLDA is the CPU's acknowledge. A grant is only issued in a cycle where
// HRQ and HLDA are both high, and HRQ only drops after the service ends or
// HLDA is withdrawn; the next HRQ waits until HLDA has been seen low.
// ---------------------------------------------------------------------------
module dma_priority_arbiter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic [3:0] maskReg,
    input  logic       priorityType,
    input  logic       controllerDisable,
    input  logic       HLDA,
    input  logic       serviceDone,
`ifdef DMA_SW_REQUEST_EN
    input  logic       swReqWe,
    input  logic [2:0] swReqData,
`endif
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic       grantValid,
    output logic [1:0] grantChannel,
    output logic [7:0] priorityOrder,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] FIXED_ORDER = 8'b11_10_01_00;

    state_t     state;
    state_t     state_next;
    logic [3:0] eff_req;
    logic [7:0] scan_order;
    logic [7:0] rot_order;
    logic       win_found;
    logic [1:0] win_ch;
    logic       latch_grant;
    logic       service_end;

`ifdef DMA_SW_REQUEST_EN
    logic [3:0] sw_req;
    logic [3:0] sw_req_next;

    assign eff_req = (DREQ & ~maskReg) | sw_req;

    // Clear on service end first so that a same-cycle write overrides it.
    always_comb begin
        sw_req_next = sw_req;
        if (service_end)
            sw_req_next[grantChannel] = 1'b0;
        if (swReqWe)
            sw_req_next[swReqData[1:0]] = swReqData[2];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            sw_req <= 4'b0000;
        else
            sw_req <= sw_req_next;
    end
`else
    assign eff_req = DREQ & ~maskReg;
`endif

    assign state_dbg = state;

    // In fixed mode the scan uses the fixed order directly so a mode switch
    // takes effect in the same cycle, before the register is re-forced.
    assign scan_order = priorityType ? priorityOrder : FIXED_ORDER;

    // Lowest slot index has highest priority: scanning downward lets the
    // last hit (lowest slot) win.
    always_comb begin
        win_found = 1'b0;
        win_ch    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eff_req[scan_order[2*i +: 2]]) begin
                win_found = 1'b1;
                win_ch    = scan_order[2*i +: 2];
            end
        end
    end

    // Serviced channel becomes lowest, its successor highest.
    always_comb begin
        rot_order = 8'd0;
        for (int i = 0; i < 4; i++)
            rot_order[2*i +: 2] = grantChannel + 2'(i) + 2'd1;
    end

    always_comb begin
        state_next  = state;
        latch_grant = 1'b0;
        service_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((|eff_req) && !controllerDisable)
                    state_next = ST_REQ;
            end
            ST_REQ: begin
                if (HLDA) begin
                    if (win_found) begin
                        state_next  = ST_GRANT;
                        latch_grant = 1'b1;
                    end else begin
                        state_next = ST_RELEASE;
                    end
                end
            end
            ST_GRANT: begin
                // Losing HLDA mid-service is a protocol violation: abandon
                // the service without counting it for rotation.
                if (!HLDA) begin
                    state_next = ST_RELEASE;
                end else if (serviceDone) begin
                    state_next  = ST_RELEASE;
                    service_end = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!HLDA)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= ST_IDLE;
            HRQ           <= 1'b0;
            DACK          <= 4'b0000;
            grantValid    <= 1'b0;
            grantChannel  <= 2'b00;
            priorityOrder <= FIXED_ORDER;
        end else begin
            state      <= state_next;
            HRQ        <= (state_next == ST_REQ) || (state_next == ST_GRANT);
            grantValid <= (state_next == ST_GRANT);
            if (latch_grant)
                grantChannel <= win_ch;
            if (state_next == ST_GRANT)
                DACK <= 4'b0001 << (latch_grant ? win_ch : grantChannel);
            else
                DACK <= 4'b0000;
            if (!priorityType)
                priorityOrder <= FIXED_ORDER;
            else if (service_end)
                priorityOrder <= rot_order;
        end
    end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Channel arbiter and bus-hold sequencer for the four-channel DMA controller. Samples DREQ against the mask register, resolves fixed or rotating priority, runs the HRQ/HLDA handshake with the CPU, and drives one-hot DACK to the timing-control block for the duration of one service. It owns the live priority order that the timing control and status logic read.

## Interface
- No parameters; channel count is fixed at 4.
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DREQ  in  4  channel requests, active-high, level-sensitive.
- maskReg  in  4  per-channel mask; 1 = channel ignored.
- priorityType  in  1  commandReg priority bit; 0 = fixed (ch0 highest), 1 = rotating.
- controllerDisable  in  1  commandReg disable bit; 1 = no new HRQ.
- HLDA  in  1  hold acknowledge from the CPU.
- serviceDone  in  1  one-cycle pulse from timing control when the current service ends (block end, single-transfer end, or EOP).
- HRQ  out  1  hold request to the CPU.
- DACK  out  4  one-hot grant, active-high.
- grantValid  out  1  1 while DACK is non-zero.
- grantChannel  out  2  encoded granted channel; holds the last value when idle.
- priorityOrder  out  8  four 2-bit channel IDs, [1:0] highest priority to [7:6] lowest.
- swReqWe  in  1  software request write strobe (only with DMA_SW_REQUEST_EN).
- swReqData  in  3  [2] = set/clear, [1:0] = channel (only with DMA_SW_REQUEST_EN).

## Operation
- Effective request: effReq = DREQ & ~maskReg, OR'd with swReq when the macro is enabled.
- The winner is the first channel in priorityOrder, scanning from [1:0] upward, whose effReq bit is 1.
- States:
  - IDLE: entered from reset. Go to REQ when |effReq and !controllerDisable.
  - REQ: HRQ = 1.
    - If HLDA = 1 and |effReq: latch the winner as evaluated in that cycle, go to GRANT.
    - If HLDA = 1 and effReq = 0: go to RELEASE.
    - HLDA = 0: remain in REQ, even if requests drop.
  - GRANT: HRQ = 1, DACK = onehot(grant), grantValid = 1.
    - DREQ, mask and disable changes are ignored; the grant holds until serviceDone.
    - On serviceDone, go to RELEASE.
  - RELEASE: HRQ = 0, DACK = 0. Wait for HLDA = 0, then go to IDLE.
- Rotating priority (priorityType = 1):
  - On serviceDone, priorityOrder rotates so the serviced channel becomes lowest and its successor (ch+1 mod 4) becomes highest.
  - Example: serving ch1 yields order 01_00_11_10.
- Fixed priority (priorityType = 0): priorityOrder is forced to 11_10_01_00 every cycle.
- controllerDisable asserted during REQ or GRANT does not abort the current sequence; it only blocks the next IDLE→REQ transition.
- HLDA dropping during GRANT (protocol violation): go to RELEASE immediately. DACK = 0 next cycle; priorityOrder is not rotated.

## Timing
- Reset values: HRQ = 0, DACK = 4'b0000, grantValid = 0, grantChannel = 2'b00, priorityOrder = 8'b11_10_01_00, swReq = 4'b0000, state = IDLE.
- All outputs are registered.
- DREQ to HRQ: effReq seen in cycle N, HRQ = 1 in cycle N+1.
- HLDA to DACK: HLDA = 1 sampled in cycle M, DACK valid in cycle M+1.
- serviceDone to release: serviceDone in cycle K, DACK = 0 and HRQ = 0 in cycle K+1, priorityOrder updated in cycle K+1.
- Back-to-back service: after HLDA falls, IDLE takes one cycle before the next HRQ. The minimum HRQ-low gap is 2 cycles.
- RESET asserted mid-service: all outputs return to reset values asynchronously; no rotation is recorded.

## Configuration
- DMA_SW_REQUEST_EN defined: adds a 4-bit software request register, plus swReqWe and swReqData.
  - swReqWe sets or clears bit swReqData[1:0] according to swReqData[2].
  - Software requests bypass maskReg.
  - A software request bit is cleared when the service of that channel ends (serviceDone while it is granted).
  - A write and a serviceDone-clear to the same bit in the same cycle: the write wins.
- DMA_SW_REQUEST_EN undefined: the register and ports are absent; effReq = DREQ & ~maskReg.

## Test plan
- Fixed priority, DREQ = 4'b1010, mask = 0, HLDA raised 2 cycles after HRQ → HRQ 1 cycle after DREQ, DACK = 4'b0010 1 cycle after HLDA, grantChannel = 1.
- Rotating priority, DREQ = 4'b1111 held, HLDA follows HRQ, serviceDone after each grant → DACK sequence 0001, 0010, 0100, 1000, 0001; priorityOrder = 00_11_10_01 after the first service.
- DREQ = 4'b0001 with maskReg = 4'b0001 → HRQ stays 0; clearing the mask gives HRQ = 1 next cycle.
- DREQ pulse 4'b0100 dropped before HLDA rises → REQ→RELEASE, DACK stays 0000, HRQ = 0 the cycle after HLDA = 1.
- RESET pulsed during GRANT with DACK = 4'b1000 → DACK = 0000, HRQ = 0 and priorityOrder = 11_10_01_00 immediately.
- With DMA_SW_REQUEST_EN: swReqData = 3'b110, maskReg = 4'b1111, DREQ = 0 → DACK = 4'b0100 after HLDA; swReq bit 2 is clear after serviceDone.
